// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a valid/ready handshake and a one-entry skid buffer.
// o_ready and o_valid come straight from flops, so no combinational path runs from i_ready to o_ready.
//
// Ports:
//   clk, rst (async, active-low)
//   EX side:  i_valid, o_ready, i_pc, i_rd_idx, i_alu_res, i_rs2_data, i_memop, i_inst_data, i_trap_bus
//   MEM side: o_valid, i_ready, and o_* carrying the same payload
//   i_flush:  synchronous squash of all held entries
//   o_stall_cnt: cycles with o_valid & !i_ready; present only when EX_MEM_STALL_CNT_EN is defined
module ex_mem_skid #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int MEMOP_W = 4,
    parameter int INST_W  = 32,
    parameter int TRAP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [REG_AW-1:0]  i_rd_idx,
    input  logic [XLEN-1:0]    i_alu_res,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic [MEMOP_W-1:0] i_memop,
    input  logic [INST_W-1:0]  i_inst_data,
    input  logic [TRAP_W-1:0]  i_trap_bus,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [XLEN-1:0]    o_pc,
    output logic [REG_AW-1:0]  o_rd_idx,
    output logic [XLEN-1:0]    o_alu_res,
    output logic [XLEN-1:0]    o_rs2_data,
    output logic [MEMOP_W-1:0] o_memop,
    output logic [INST_W-1:0]  o_inst_data,
    output logic [TRAP_W-1:0]  o_trap_bus
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]        o_stall_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [REG_AW-1:0]  rd_idx;
        logic [XLEN-1:0]    alu_res;
        logic [XLEN-1:0]    rs2_data;
        logic [MEMOP_W-1:0] memop;
        logic [INST_W-1:0]  inst_data;
        logic [TRAP_W-1:0]  trap_bus;
    } payload_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       valid_q;
    logic       ready_q;
    payload_t   main_q;
    payload_t   skid_q;
    payload_t   in_pl;
    logic       in_fire;
    logic       out_fire;
    logic       ld_main_in;
    logic       ld_main_skid;
    logic       ld_skid;

    assign in_pl = '{
        pc:        i_pc,
        rd_idx:    i_rd_idx,
        alu_res:   i_alu_res,
        rs2_data:  i_rs2_data,
        memop:     i_memop,
        inst_data: i_inst_data,
        trap_bus:  i_trap_bus
    };

    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready_q is low here, so only the drain side can move
                if (out_fire) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Payload loads may still happen under flush; they are
        // harmless because valid drops with the state.
        if (i_flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
        end else if (ld_main_in) begin
            main_q <= in_pl;
        end else if (ld_main_skid) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q <= '0;
        end else if (ld_skid) begin
            skid_q <= in_pl;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Wraps naturally; flush has no effect on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (valid_q && !i_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

    assign o_valid     = valid_q;
    assign o_ready     = ready_q;
    assign o_pc        = main_q.pc;
    assign o_rd_idx    = main_q.rd_idx;
    assign o_alu_res   = main_q.alu_res;
    assign o_rs2_data  = main_q.rs2_data;
    assign o_memop     = main_q.memop;
    assign o_inst_data = main_q.inst_data;
    assign o_trap_bus  = main_q.trap_bus;

endmodule
